// File: rtl/vvc_bs_pkg.sv
// Shared constants and FSM state type for the
// arithmetic-decoder bitstream fetcher.
package vvc_bs_pkg;

  localparam int BS_WORD_W      = 9;
  localparam int BS_BUF_W       = 2 * BS_WORD_W;
  localparam int BS_TIMEOUT_CYC = 16;
  localparam int BS_NUM_W       = 4;
  localparam int BS_CNT_W       = 5;

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } fetch_state_e;

endpackage

// File: rtl/bitstream_fetcher.sv
// Word fetcher feeding a FIFO bit buffer; hands the
// oldest n bits to the arithmetic decoder on request.
module bitstream_fetcher
  import vvc_bs_pkg::*;
#(
  parameter int WORD_W      = BS_WORD_W,
  parameter int BUF_W       = 2 * WORD_W,
  parameter int TIMEOUT_CYC = BS_TIMEOUT_CYC
) (
  input  logic                clk,
  input  logic                rst,
  output logic                request,
  input  logic [WORD_W-1:0]   data,
  input  logic                data_ready,
  input  logic                bits_req,
  input  logic [BS_NUM_W-1:0] bits_num,
  output logic [WORD_W-1:0]   bits_out,
  output logic                bits_valid,
  output logic [BS_CNT_W-1:0] bit_count,
  output logic                timeout_err
);

  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMR_W-1:0] TMR_LAST =
    TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [BS_CNT_W-1:0] WORD_CNT =
    BS_CNT_W'(WORD_W);
  localparam logic [BS_CNT_W-1:0] BUF_CNT =
    BS_CNT_W'(BUF_W);

  fetch_state_e state_q, state_d;

  logic [TMR_W-1:0]    tmr_q, tmr_d;
  logic [BUF_W-1:0]    buf_q, buf_d;
  logic [BS_CNT_W-1:0] cnt_q, cnt_d;
  logic [WORD_W-1:0]   out_q, out_d;
  logic                vld_q, vld_d;
  logic                err_q, err_d;

  logic [BS_CNT_W-1:0] num_ext;
  logic [BS_CNT_W-1:0] n_c;
  logic [BS_CNT_W-1:0] take_n;
  logic [BS_CNT_W-1:0] cnt_left;
  logic [BUF_W-1:0]    word_ext;
  logic                take;
  logic                append;

  // Buffer is MSB-aligned: the oldest bit sits at buf_q[BUF_W-1].
  always_comb begin
    num_ext  = BS_CNT_W'(bits_num);
    n_c      = (num_ext > WORD_CNT) ? WORD_CNT : num_ext;
    take     = bits_req && (cnt_q >= n_c);
    take_n   = take ? n_c : '0;
    append   = (state_q == S_WAIT) && data_ready;
    cnt_left = cnt_q - take_n;
    word_ext = {data, {(BUF_W - WORD_W){1'b0}}};

    buf_d = buf_q << take_n;
    cnt_d = cnt_left;
    if (append) begin
      buf_d = buf_d | (word_ext >> cnt_left);
      cnt_d = cnt_left + WORD_CNT;
    end

    vld_d = take;
    out_d = out_q;
    if (take) begin
      out_d = WORD_W'(buf_q >> (BUF_CNT - n_c));
    end
  end

  always_comb begin
    request = 1'b0;
    state_d = state_q;
    tmr_d   = tmr_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (!rst && (cnt_q <= WORD_CNT)) begin
          request = 1'b1;
          state_d = S_WAIT;
          tmr_d   = '0;
        end
      end
      S_WAIT: begin
        if (data_ready) begin
          state_d = S_IDLE;
        end else if (tmr_q == TMR_LAST) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      tmr_q   <= '0;
      buf_q   <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
    end
  end

  assign bits_out    = out_q;
  assign bits_valid  = vld_q;
  assign bit_count   = cnt_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_bitstream_fetcher.sv
// Directed vectors and hand-built sequences for the
// bitstream fetcher: fetch, consume, stall, timeout, reset.
module tb_bitstream_fetcher;

  logic       clk = 1'b0;
  logic       rst;
  logic       request;
  logic [8:0] data;
  logic       data_ready;
  logic       bits_req;
  logic [3:0] bits_num;
  logic [8:0] bits_out;
  logic       bits_valid;
  logic [4:0] bit_count;
  logic       timeout_err;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [3:0] num;
    logic       vld;
    logic [8:0] out;
    logic [4:0] cnt;
  } vec_t;

  vec_t tbl[7];

  bitstream_fetcher dut (
    .clk         (clk),
    .rst         (rst),
    .request     (request),
    .data        (data),
    .data_ready  (data_ready),
    .bits_req    (bits_req),
    .bits_num    (bits_num),
    .bits_out    (bits_out),
    .bits_valid  (bits_valid),
    .bit_count   (bit_count),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    bits_req   = 1'b0;
    bits_num   = '0;
    data       = '0;
    data_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  // Waits (bounded) for a request, answers it one cycle later.
  task automatic serve(input logic [8:0] w);
    int k = 0;
    while (!request && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("serve_req", {31'b0, request}, 32'd1);
    @(negedge clk);
    data       = w;
    data_ready = 1'b1;
    @(negedge clk);
    data_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got hang expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // stream 110100011 001011100 from words 1A3, 05C
    tbl[0] = '{4'd0,  1'b1, 9'h000, 5'd18};
    tbl[1] = '{4'd3,  1'b1, 9'h006, 5'd15};
    tbl[2] = '{4'd2,  1'b1, 9'h002, 5'd13};
    tbl[3] = '{4'd1,  1'b1, 9'h000, 5'd12};
    tbl[4] = '{4'd15, 1'b1, 9'h0CB, 5'd3};
    tbl[5] = '{4'd3,  1'b1, 9'h004, 5'd0};
    tbl[6] = '{4'd1,  1'b0, 9'h004, 5'd0};

    // reset state, first fetch and re-request
    rst        = 1'b1;
    bits_req   = 1'b0;
    bits_num   = '0;
    data       = '0;
    data_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req", {31'b0, request}, 32'd0);
    chk("rst_cnt", {27'b0, bit_count}, 32'd0);
    chk("rst_vld", {31'b0, bits_valid}, 32'd0);
    chk("rst_out", {23'b0, bits_out}, 32'd0);
    chk("rst_err", {31'b0, timeout_err}, 32'd0);
    rst = 1'b0;
    #1;
    chk("first_req", {31'b0, request}, 32'd1);
    @(negedge clk);
    chk("wait_noreq", {31'b0, request}, 32'd0);
    data       = 9'h167;
    data_ready = 1'b1;
    @(negedge clk);
    data_ready = 1'b0;
    chk("fill_cnt", {27'b0, bit_count}, 32'd9);
    chk("second_req", {31'b0, request}, 32'd1);

    // consume 4 then 5 from 9'h167
    bits_req = 1'b1;
    bits_num = 4'd4;
    @(negedge clk);
    chk("c4_vld", {31'b0, bits_valid}, 32'd1);
    chk("c4_out", {23'b0, bits_out}, 32'h00B);
    chk("c4_cnt", {27'b0, bit_count}, 32'd5);
    bits_num = 4'd5;
    @(negedge clk);
    chk("c5_vld", {31'b0, bits_valid}, 32'd1);
    chk("c5_out", {23'b0, bits_out}, 32'h007);
    chk("c5_cnt", {27'b0, bit_count}, 32'd0);
    bits_req = 1'b0;
    @(negedge clk);
    chk("hold_vld", {31'b0, bits_valid}, 32'd0);
    chk("hold_out", {23'b0, bits_out}, 32'h007);

    // stall on empty buffer until the word lands
    bits_req = 1'b1;
    bits_num = 4'd9;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("stall_vld", {31'b0, bits_valid}, 32'd0);
    end
    data       = 9'h0A5;
    data_ready = 1'b1;
    @(negedge clk);
    data_ready = 1'b0;
    chk("stall_land_vld", {31'b0, bits_valid}, 32'd0);
    chk("stall_land_cnt", {27'b0, bit_count}, 32'd9);
    @(negedge clk);
    chk("stall_vld_out", {31'b0, bits_valid}, 32'd1);
    chk("stall_out", {23'b0, bits_out}, 32'h0A5);
    chk("stall_cnt", {27'b0, bit_count}, 32'd0);
    bits_req = 1'b0;

    // table: back-to-back consumes over two words
    do_reset();
    serve(9'h1A3);
    serve(9'h05C);
    chk("tbl_fill", {27'b0, bit_count}, 32'd18);
    chk("tbl_noreq", {31'b0, request}, 32'd0);
    for (int i = 0; i < 7; i++) begin
      bits_req = 1'b1;
      bits_num = tbl[i].num;
      @(negedge clk);
      chk($sformatf("tbl%0d_vld", i),
          {31'b0, bits_valid}, {31'b0, tbl[i].vld});
      chk($sformatf("tbl%0d_out", i),
          {23'b0, bits_out}, {23'b0, tbl[i].out});
      chk($sformatf("tbl%0d_cnt", i),
          {27'b0, bit_count}, {27'b0, tbl[i].cnt});
    end
    bits_req = 1'b0;

    // append and consume in the same cycle
    do_reset();
    serve(9'h0F0);
    @(negedge clk);
    data       = 9'h1FF;
    data_ready = 1'b1;
    bits_req   = 1'b1;
    bits_num   = 4'd3;
    @(negedge clk);
    data_ready = 1'b0;
    chk("mix_vld", {31'b0, bits_valid}, 32'd1);
    chk("mix_out", {23'b0, bits_out}, 32'h003);
    chk("mix_cnt", {27'b0, bit_count}, 32'd15);
    bits_num = 4'd6;
    @(negedge clk);
    chk("mix6_out", {23'b0, bits_out}, 32'h030);
    chk("mix6_cnt", {27'b0, bit_count}, 32'd9);
    bits_num = 4'd9;
    @(negedge clk);
    chk("mix9_out", {23'b0, bits_out}, 32'h1FF);
    chk("mix9_cnt", {27'b0, bit_count}, 32'd0);
    bits_req = 1'b0;

    // silent source: timeout, retry, sticky flag
    do_reset();
    begin
      int k = 0;
      while (!timeout_err && k < 40) begin
        @(negedge clk);
        k++;
      end
      chk("to_latency", k, 32'd17);
    end
    chk("to_retry_req", {31'b0, request}, 32'd1);
    serve(9'h100);
    repeat (3) @(negedge clk);
    chk("to_sticky", {31'b0, timeout_err}, 32'd1);
    do_reset();
    chk("to_cleared", {31'b0, timeout_err}, 32'd0);

    // reset during WAIT, late data ignored
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst        = 1'b0;
    data       = 9'h1FF;
    data_ready = 1'b1;
    #1;
    chk("late_req", {31'b0, request}, 32'd1);
    @(negedge clk);
    data_ready = 1'b0;
    chk("late_cnt", {27'b0, bit_count}, 32'd0);
    chk("late_vld", {31'b0, bits_valid}, 32'd0);
    @(negedge clk);
    chk("late_cnt2", {27'b0, bit_count}, 32'd0);

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule

// File: doc/bitstream_fetcher.md
BITSTREAM_FETCHER -- requirements
Module: bitstream_fetcher

Interface
REQ-001 Parameter WORD_W, default 9: width of each word delivered by the file source.
REQ-002 Parameter BUF_W, default 18: bit-buffer capacity, fixed at 2*WORD_W.
REQ-003 Parameter TIMEOUT_CYC, default 16: maximum cycles to wait for data_ready after a request.
REQ-004 clk  in  1  single clock; all logic is rising-edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 request  out  1  one-cycle pulse asking the file source for the next word.
REQ-007 data  in  WORD_W  word from the source; data[8] is the earliest bit in the stream.
REQ-008 data_ready  in  1  source qualifier; data is valid in any cycle where this is high.
REQ-009 bits_req  in  1  consumer (arithmetic decoder) request for bits_num bits.
REQ-010 bits_num  in  4  bit count requested: 0..9; values 10..15 are clamped to 9.
REQ-011 bits_out  out  WORD_W  requested bits, right-aligned, MSB = oldest bit, zero-filled above.
REQ-012 bits_valid  out  1  one-cycle pulse qualifying bits_out.
REQ-013 bit_count  out  5  bits currently buffered, 0..18.
REQ-014 timeout_err  out  1  sticky flag: the source failed to answer within TIMEOUT_CYC.

Function
REQ-015 Fetch FSM states: IDLE and WAIT.
REQ-016 In IDLE with bit_count <= 9, the block SHALL pulse request for one cycle and enter WAIT on the next edge.
REQ-017 In WAIT, data_ready=1 SHALL append data below the buffered bits, add 9 to bit_count, and return to IDLE.
REQ-018 data_ready received in IDLE SHALL be ignored: no append and no count change.
REQ-019 In WAIT, a cycle counter SHALL increment each cycle; reaching TIMEOUT_CYC without data_ready SHALL set timeout_err and return to IDLE, which re-requests.
REQ-020 Consume rule: bits_req=1 with bit_count >= n (n = clamped bits_num) in cycle t SHALL give bits_valid=1 in cycle t+1, with bits_out holding the oldest n bits; those bits are removed from the buffer.
REQ-021 If bit_count < n, the request stalls with no bits_valid; the consumer holds bits_req and bits_num stable until bits_valid.
REQ-022 bits_req=1 in the bits_valid cycle SHALL be treated as a new request, giving a sustained rate of one consume per cycle.
REQ-023 An append and a consume in the same cycle SHALL both take effect: bit_count_next = bit_count - n + 9, and the consume is judged against the pre-append count.
REQ-024 n=0 SHALL return bits_valid with bits_out=0 and consume nothing.
REQ-025 bit_count SHALL never exceed 18; the fetch threshold of REQ-016 guarantees this.
REQ-026 bits_out SHALL hold its last value whenever bits_valid=0.

Reset
REQ-027 rst=1 SHALL clear request, bits_valid, bits_out, bit_count, timeout_err, the buffer and the timeout counter, and force the FSM to IDLE.
REQ-028 Reset during WAIT SHALL abandon the outstanding request; a late data_ready arriving after reset SHALL be ignored per REQ-018.
REQ-029 The first request SHALL pulse in the first cycle after rst deasserts.

Structure
REQ-030 Shared package vvc_bs_pkg SHALL hold WORD_W, BUF_W, TIMEOUT_CYC, the bits_num width and the FSM state enum.
REQ-031 The block SHALL be a single module with no sub-modules; the buffer shift/extract is inline logic.

Verification
REQ-032 Reset release, source answers 9'h167 one cycle after request -> request pulses once, bit_count=9, then a second request pulse follows.
REQ-033 Buffer holds 9'h167; bits_num=4 -> bits_out=9'h00B; then bits_num=5 -> bits_out=9'h007; bit_count returns to 0 absent refill.
REQ-034 bits_num=9 with bit_count=0 -> no bits_valid until the word arrives; next cycle bits_out equals that word.
REQ-035 Same cycle: data_ready with 9'h1FF and consume of 3 bits from count 9 -> bit_count=15, and the FIFO bit order is preserved across the boundary.
REQ-036 Source silent for 16 cycles -> timeout_err=1, FSM back to IDLE, request re-pulses; the flag stays set until rst.
REQ-037 rst asserted during WAIT, then data_ready arrives -> bit_count stays 0, no bits_valid, and a fresh request pulses after reset.
